// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle signed divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : controller state encoding (IDLE/RUN/FIX)
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration.
//   acc_in  [WIDTH:0]   partial remainder before the step
//   q_in    [WIDTH-1:0] partial quotient / remaining dividend bits
//   divisor [WIDTH-1:0] divisor magnitude
//   acc_out [WIDTH:0]   partial remainder after the step
//   q_out   [WIDTH-1:0] quotient shifted left with the new bit in q_out[0]
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   acc_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvsr;
  logic           ge;

  always_comb begin
    shifted = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
    dvsr    = {1'b0, divisor};
    // acc stays below the divisor, so its top bit is always clear; if it were
    // set, the shifted value would certainly exceed the divisor.
    ge      = acc_in[WIDTH] | (shifted >= dvsr);
    acc_out = shifted;
    q_out   = {q_in[WIDTH-2:0], 1'b0};
    if (ge) begin
      acc_out = shifted - dvsr;
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

// File: rtl/div_unit.sv
// Multi-cycle signed integer divider (MIPS DIV).
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   DivStart : one-cycle start pulse
//   DivA     : dividend (two's complement)
//   DivB     : divisor (two's complement)
//   DivHI    : remainder, registered, holds last result
//   DivLO    : quotient, registered, holds last result
//   DivBusy  : high while an operation is in progress
//   DivDone  : one-cycle pulse when DivHI/DivLO update
//   DivZero  : one-cycle pulse when a start sees DivB == 0
// Quotient truncates toward zero; remainder takes the dividend's sign.
// 0x80000000 / -1 wraps to LO=0x80000000, HI=0.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] DivA,
  input  logic [WIDTH-1:0] DivB,
  output logic [WIDTH-1:0] DivHI,
  output logic [WIDTH-1:0] DivLO,
  output logic             DivBusy,
  output logic             DivDone,
  output logic             DivZero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             sign_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;

  // Plain WIDTH-bit negation: the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    mag_a = DivA[WIDTH-1] ? (~DivA + 1'b1) : DivA;
    mag_b = DivB[WIDTH-1] ? (~DivB + 1'b1) : DivB;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_in  (acc),
    .q_in    (q),
    .divisor (divisor),
    .acc_out (acc_next),
    .q_out   (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      acc     <= '0;
      q       <= '0;
      divisor <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      count   <= '0;
      DivHI   <= '0;
      DivLO   <= '0;
      DivBusy <= 1'b0;
      DivDone <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      DivDone <= 1'b0;
      DivZero <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (DivStart) begin
            if (DivB == '0) begin
              DivZero <= 1'b1;
            end else begin
              acc     <= '0;
              q       <= mag_a;
              divisor <= mag_b;
              sign_q  <= DivA[WIDTH-1] ^ DivB[WIDTH-1];
              sign_r  <= DivA[WIDTH-1];
              count   <= CW'(WIDTH);
              DivBusy <= 1'b1;
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          DivLO   <= sign_q ? (~q + 1'b1) : q;
          DivHI   <= sign_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
          DivDone <= 1'b1;
          DivBusy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : div_unit

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         DivStart;
  logic [W-1:0] DivA;
  logic [W-1:0] DivB;
  logic [W-1:0] DivHI;
  logic [W-1:0] DivLO;
  logic         DivBusy;
  logic         DivDone;
  logic         DivZero;

  int unsigned n_eval = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc;
  logic [W-1:0] prior_lo = '0;
  logic [W-1:0] prior_hi = '0;

  div_unit #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .DivStart (DivStart),
    .DivA     (DivA),
    .DivB     (DivB),
    .DivHI    (DivHI),
    .DivLO    (DivLO),
    .DivBusy  (DivBusy),
    .DivDone  (DivDone),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: 64-bit signed arithmetic, truncated to 32 bits ({rem, quo}).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] qb, rb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa - qq * sb;
    qb = 64'(qq);
    rb = 64'(rr);
    return {rb[31:0], qb[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; presents a start pulse sampled at the next edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    DivStart = 1'b1;
    DivA = a;
    DivB = b;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    DivStart = 1'b0;
    DivA = $urandom;
    DivB = $urandom;
    check("busy_after_start", 32'(DivBusy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    bit seen;
    exp = ref_div(a, b);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (DivDone) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc - start_cyc, 32'd33);
    check({tag, "_lo"}, DivLO, exp[31:0]);
    check({tag, "_hi"}, DivHI, exp[63:32]);
    check({tag, "_busy_fall"}, 32'(DivBusy), 32'd0);
    check({tag, "_nozero"}, 32'(DivZero), 32'd0);
    prior_lo = exp[31:0];
    prior_hi = exp[63:32];
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(DivDone), 32'd0);
  endtask

  task automatic zero_op(input string tag, input logic [31:0] a);
    DivStart = 1'b1;
    DivA = a;
    DivB = '0;
    @(posedge clk);
    #1;
    DivStart = 1'b0;
    check({tag, "_zero"}, 32'(DivZero), 32'd1);
    check({tag, "_busy"}, 32'(DivBusy), 32'd0);
    check({tag, "_nodone"}, 32'(DivDone), 32'd0);
    check({tag, "_lo_kept"}, DivLO, prior_lo);
    check({tag, "_hi_kept"}, DivHI, prior_hi);
    @(posedge clk);
    #1;
    check({tag, "_zero_pulse"}, 32'(DivZero), 32'd0);
    check({tag, "_busy_idle"}, 32'(DivBusy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    DivStart = 1'b0;
    DivA = '0;
    DivB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", DivHI, 32'd0);
    check("rst_lo", DivLO, 32'd0);
    check("rst_busy", 32'(DivBusy), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_done", 32'(DivDone), 32'd0);
    check("post_rst_zero", 32'(DivZero), 32'd0);

    // Directed cases
    start_op(32'd7, 32'd2);
    wait_done("t1", 32'd7, 32'd2);
    check("t1_lo_const", DivLO, 32'd3);
    check("t1_hi_const", DivHI, 32'd1);

    start_op(32'hFFFF_FFF9, 32'd2);
    wait_done("t2", 32'hFFFF_FFF9, 32'd2);
    check("t2_lo_const", DivLO, 32'hFFFF_FFFD);
    check("t2_hi_const", DivHI, 32'hFFFF_FFFF);

    zero_op("t3", 32'd5);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("t4", 32'h8000_0000, 32'hFFFF_FFFF);
    check("t4_lo_const", DivLO, 32'h8000_0000);
    check("t4_hi_const", DivHI, 32'd0);

    // Async reset in the middle of an operation
    start_op(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_rst_busy", 32'(DivBusy), 32'd0);
    check("t5_rst_lo", DivLO, 32'd0);
    check("t5_rst_hi", DivHI, 32'd0);
    check("t5_rst_done", 32'(DivDone), 32'd0);
    check("t5_rst_zero", 32'(DivZero), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    prior_lo = '0;
    prior_hi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_idle_busy", 32'(DivBusy), 32'd0);
    check("t5_idle_done", 32'(DivDone), 32'd0);
    start_op(32'd100, 32'd7);
    wait_done("t5", 32'd100, 32'd7);
    check("t5_lo_const", DivLO, 32'd14);
    check("t5_hi_const", DivHI, 32'd2);

    // A second start while busy is ignored
    start_op(32'd9, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    DivStart = 1'b1;
    DivA = 32'd1;
    DivB = 32'd1;
    @(posedge clk);
    #1;
    DivStart = 1'b0;
    wait_done("t6", 32'd9, 32'd4);
    check("t6_lo_const", DivLO, 32'd2);
    check("t6_hi_const", DivHI, 32'd1);

    // Corner operands
    start_op(32'h8000_0000, 32'd1);
    wait_done("c1", 32'h8000_0000, 32'd1);
    start_op(32'h7FFF_FFFF, 32'h8000_0000);
    wait_done("c2", 32'h7FFF_FFFF, 32'h8000_0000);
    start_op(32'd0, 32'hFFFF_FFF3);
    wait_done("c3", 32'd0, 32'hFFFF_FFF3);
    start_op(32'h8000_0000, 32'h8000_0000);
    wait_done("c4", 32'h8000_0000, 32'h8000_0000);

    // Randomized operations, including small divisors and occasional zero
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i % 8 == 7) begin
        zero_op("rnd_z", ra);
      end else if (rb == '0) begin
        zero_op("rnd_z", ra);
      end else begin
        start_op(ra, rb);
        wait_done("rnd", ra, rb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_div_unit
